serial_frame_rx: RTL and testbench

Serial frame receiver that consumes the bit stream produced by the 4-bit shift register stage (its `serialout`) and rebuilds parallel words. It detects a start bit, shifts in `DATA_BITS` data bits MSB- or LSB-first, checks an optional even-parity bit and a stop bit, then presents the word with a one-cycle valid strobe. Bits advance only on `enable`-qualified clocks, so one `enable` pulse on the upstream shifter corresponds to one bit sampled here.

---
 rtl/serial_frame_rx_if.sv | 23 ++
 rtl/serial_frame_rx.sv | 110 +++++++++++
 tb/tb_serial_frame_rx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial line in / parallel word out bundle for serial_frame_rx
interface serial_frame_rx_if #(
  parameter int DATA_BITS = 4
);
  logic                 enable;
  logic                 msbfirst;
  logic                 serialin;
  logic [DATA_BITS-1:0] pdataout;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output enable, msbfirst, serialin,
    input  pdataout, valid, parity_err, frame_err, busy
  );

  modport slave (
    input  enable, msbfirst, serialin,
    output pdataout, valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - start/data/parity/stop frame receiver with enable-qualified bit timing
module serial_frame_rx #(
  parameter int DATA_BITS = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input logic             clock,
  input logic             reset,
  serial_frame_rx_if.slave rx
);
  localparam int CW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] pdata_q, pdata_d;
  logic                 dir_q, dir_d;
  logic                 pbit_q, pbit_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pdata_q <= '0;
      dir_q   <= 1'b0;
      pbit_q  <= 1'b0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pdata_q <= pdata_d;
      dir_q   <= dir_d;
      pbit_q  <= pbit_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  // Status strobes default low so any non-enable edge clears them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pdata_d = pdata_q;
    dir_d   = dir_q;
    pbit_d  = pbit_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (rx.enable) begin
      case (state_q)
        IDLE: begin
          if (!rx.serialin) begin
            state_d = DATA;
            dir_d   = rx.msbfirst;
            cnt_d   = '0;
            sh_d    = '0;
          end
        end
        DATA: begin
          sh_d = dir_q ? {sh_q[DATA_BITS-2:0], rx.serialin}
                       : {rx.serialin, sh_q[DATA_BITS-1:1]};
          if (cnt_q != CW'(DATA_BITS)) cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_BITS - 1)) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          pbit_d  = rx.serialin;
          state_d = STOP;
        end
        STOP: begin
          pdata_d = sh_q;
          valid_d = 1'b1;
          perr_d  = PARITY_EN & (^sh_q ^ pbit_q);
          ferr_d  = ~rx.serialin;
          // A low stop bit parks in WAIT_HIGH so a stuck line cannot look like a new start.
          state_d = rx.serialin ? IDLE : WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (rx.serialin) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign rx.pdataout   = pdata_q;
  assign rx.valid      = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.busy       = busy_q;
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - vector-table bench for serial_frame_rx
module tb_serial_frame_rx;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  serial_frame_rx_if #(.DATA_BITS(4)) sif ();
  serial_frame_rx_if #(.DATA_BITS(4)) nif ();

  assign nif.enable   = sif.enable;
  assign nif.msbfirst = sif.msbfirst;
  assign nif.serialin = sif.serialin;

  serial_frame_rx #(.DATA_BITS(4), .PARITY_EN(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (sif.slave)
  );

  serial_frame_rx #(.DATA_BITS(4), .PARITY_EN(1'b0)) dut_np (
    .clock (clock),
    .reset (reset),
    .rx    (nif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       msb;
    logic [3:0] line;
    logic       pbit;
    int         gap;
    logic       toggle;
    logic [3:0] exp_data;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_edge(input logic b, input int gap);
    repeat (gap) begin
      sif.enable = 1'b0;
      @(posedge clock); #1;
    end
    sif.serialin = b;
    sif.enable   = 1'b1;
    @(posedge clock); #1;
    sif.enable   = 1'b0;
    sif.serialin = 1'b1;
  endtask

  task automatic send_frame(input logic msb, input logic [3:0] line, input logic pbit,
                            input logic stop, input int gap, input logic toggle);
    sif.msbfirst = msb;
    bit_edge(1'b0, gap);
    chk("busy_after_start", {31'b0, sif.busy}, 32'd1);
    chk("valid_after_start", {31'b0, sif.valid}, 32'd0);
    if (toggle) sif.msbfirst = ~msb;
    for (int i = 3; i >= 0; i--) bit_edge(line[i], gap);
    bit_edge(pbit, gap);
    bit_edge(stop, gap);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pdata"}, {28'b0, sif.pdataout}, 32'd0);
    chk({tag, "_valid"}, {31'b0, sif.valid}, 32'd0);
    chk({tag, "_perr"},  {31'b0, sif.parity_err}, 32'd0);
    chk({tag, "_ferr"},  {31'b0, sif.frame_err}, 32'd0);
    chk({tag, "_busy"},  {31'b0, sif.busy}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //         msb   line     pbit  gap toggle data   perr
    vecs[0] = '{1'b1, 4'b1010, 1'b0, 0, 1'b0, 4'hA, 1'b0};
    vecs[1] = '{1'b0, 4'b1010, 1'b0, 0, 1'b0, 4'h5, 1'b0};
    vecs[2] = '{1'b0, 4'b1100, 1'b0, 0, 1'b1, 4'h3, 1'b0};
    vecs[3] = '{1'b1, 4'b1011, 1'b0, 0, 1'b0, 4'hB, 1'b1};
    vecs[4] = '{1'b1, 4'b1100, 1'b0, 2, 1'b0, 4'hC, 1'b0};
    vecs[5] = '{1'b0, 4'b0011, 1'b1, 0, 1'b0, 4'hC, 1'b1};

    reset        = 1'b1;
    sif.enable   = 1'b0;
    sif.msbfirst = 1'b0;
    sif.serialin = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk_outputs_zero("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].msb, vecs[v].line, vecs[v].pbit, 1'b1, vecs[v].gap, vecs[v].toggle);
      chk($sformatf("v%0d_valid", v), {31'b0, sif.valid}, 32'd1);
      chk($sformatf("v%0d_data", v), {28'b0, sif.pdataout}, {28'b0, vecs[v].exp_data});
      chk($sformatf("v%0d_perr", v), {31'b0, sif.parity_err}, {31'b0, vecs[v].exp_perr});
      chk($sformatf("v%0d_ferr", v), {31'b0, sif.frame_err}, 32'd0);
      chk($sformatf("v%0d_busy", v), {31'b0, sif.busy}, 32'd0);
      @(posedge clock); #1;
      chk($sformatf("v%0d_valid_drop", v), {31'b0, sif.valid}, 32'd0);
      chk($sformatf("v%0d_data_hold", v), {28'b0, sif.pdataout}, {28'b0, vecs[v].exp_data});
    end

    // Back-to-back: second start lands on the enable edge right after the stop edge.
    send_frame(1'b1, 4'b1010, 1'b0, 1'b1, 0, 1'b0);
    chk("b2b_first_data", {28'b0, sif.pdataout}, 32'hA);
    send_frame(1'b0, 4'b1010, 1'b0, 1'b1, 0, 1'b0);
    chk("b2b_second_valid", {31'b0, sif.valid}, 32'd1);
    chk("b2b_second_data", {28'b0, sif.pdataout}, 32'h5);

    // Framing error followed by a stuck-low line.
    send_frame(1'b1, 4'b0110, 1'b0, 1'b0, 0, 1'b0);
    chk("ferr_valid", {31'b0, sif.valid}, 32'd1);
    chk("ferr_flag", {31'b0, sif.frame_err}, 32'd1);
    chk("ferr_data", {28'b0, sif.pdataout}, 32'h6);
    chk("ferr_perr", {31'b0, sif.parity_err}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      bit_edge(1'b0, 0);
      chk($sformatf("stuck%0d_busy", k), {31'b0, sif.busy}, 32'd1);
      chk($sformatf("stuck%0d_valid", k), {31'b0, sif.valid}, 32'd0);
    end
    bit_edge(1'b1, 0);
    chk("release_busy", {31'b0, sif.busy}, 32'd0);
    chk("release_data_hold", {28'b0, sif.pdataout}, 32'h6);
    send_frame(1'b1, 4'b1010, 1'b0, 1'b1, 0, 1'b0);
    chk("after_ferr_valid", {31'b0, sif.valid}, 32'd1);
    chk("after_ferr_data", {28'b0, sif.pdataout}, 32'hA);
    chk("after_ferr_flag", {31'b0, sif.frame_err}, 32'd0);
    @(posedge clock); #1;

    // Six-edge frame for the parity-less build; the parity build sees one extra idle edge as its stop.
    sif.msbfirst = 1'b1;
    bit_edge(1'b0, 0);
    for (int i = 3; i >= 0; i--) bit_edge(logic'((4'b1011 >> i) & 4'b1), 0);
    chk("np_before_stop_valid", {31'b0, nif.valid}, 32'd0);
    bit_edge(1'b1, 0);
    chk("np_valid", {31'b0, nif.valid}, 32'd1);
    chk("np_data", {28'b0, nif.pdataout}, 32'hB);
    chk("np_perr", {31'b0, nif.parity_err}, 32'd0);
    chk("np_ferr", {31'b0, nif.frame_err}, 32'd0);
    chk("np_busy", {31'b0, nif.busy}, 32'd0);
    chk("p_still_busy", {31'b0, sif.busy}, 32'd1);
    bit_edge(1'b1, 0);
    chk("p_late_valid", {31'b0, sif.valid}, 32'd1);
    chk("p_late_perr", {31'b0, sif.parity_err}, 32'd0);
    chk("np_no_second_valid", {31'b0, nif.valid}, 32'd0);
    @(posedge clock); #1;

    // Gapped partial frame aborted by an asynchronous mid-cycle reset.
    sif.msbfirst = 1'b1;
    bit_edge(1'b0, 2);
    bit_edge(1'b1, 2);
    bit_edge(1'b1, 2);
    chk("abort_busy_before", {31'b0, sif.busy}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk_outputs_zero("abort");
    @(posedge clock); #1;
    bit_edge(1'b1, 0);
    chk_outputs_zero("abort_held");
    #2;
    reset = 1'b0;
    @(posedge clock); #1;
    for (int k = 0; k < 4; k++) begin
      bit_edge(1'b1, 0);
      chk($sformatf("abort_idle%0d_valid", k), {31'b0, sif.valid}, 32'd0);
    end
    send_frame(1'b1, 4'b1100, 1'b0, 1'b1, 0, 1'b0);
    chk("post_reset_valid", {31'b0, sif.valid}, 32'd1);
    chk("post_reset_data", {28'b0, sif.pdataout}, 32'hC);
    chk("post_reset_perr", {31'b0, sif.parity_err}, 32'd0);
    chk("post_reset_ferr", {31'b0, sif.frame_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
